// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy state
// encoding and the control-bundle field layout (widths, offsets, pack/unpack).
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } stage_state_e;

  localparam int unsigned REGWR_W  = 1;
  localparam int unsigned MEMREG_W = 2;
  localparam int unsigned MEMWR_W  = 1;
  localparam int unsigned ALUCON_W = 5;
  localparam int unsigned ALUSRC_W = 1;
  localparam int unsigned REGDST_W = 2;

  localparam int unsigned CTRL_W = REGWR_W + MEMREG_W + MEMWR_W +
                                   ALUCON_W + ALUSRC_W + REGDST_W;

  // Offsets run LSB-up so regwr sits in the MSB of the flat bundle.
  localparam int unsigned REGDST_OFF = 0;
  localparam int unsigned ALUSRC_OFF = REGDST_OFF + REGDST_W;
  localparam int unsigned ALUCON_OFF = ALUSRC_OFF + ALUSRC_W;
  localparam int unsigned MEMWR_OFF  = ALUCON_OFF + ALUCON_W;
  localparam int unsigned MEMREG_OFF = MEMWR_OFF + MEMWR_W;
  localparam int unsigned REGWR_OFF  = MEMREG_OFF + MEMREG_W;

  typedef struct packed {
    logic [REGWR_W-1:0]  regwr;
    logic [MEMREG_W-1:0] memreg;
    logic [MEMWR_W-1:0]  memwr;
    logic [ALUCON_W-1:0] alucon;
    logic [ALUSRC_W-1:0] alusrc;
    logic [REGDST_W-1:0] regdst;
  } ctrl_bundle_t;

  function automatic logic [CTRL_W-1:0] pack_ctrl(input ctrl_bundle_t b);
    logic [CTRL_W-1:0] flat;
    flat = '0;
    flat[REGWR_OFF  +: REGWR_W]  = b.regwr;
    flat[MEMREG_OFF +: MEMREG_W] = b.memreg;
    flat[MEMWR_OFF  +: MEMWR_W]  = b.memwr;
    flat[ALUCON_OFF +: ALUCON_W] = b.alucon;
    flat[ALUSRC_OFF +: ALUSRC_W] = b.alusrc;
    flat[REGDST_OFF +: REGDST_W] = b.regdst;
    return flat;
  endfunction

  function automatic ctrl_bundle_t unpack_ctrl(input logic [CTRL_W-1:0] flat);
    ctrl_bundle_t b;
    b.regwr  = flat[REGWR_OFF  +: REGWR_W];
    b.memreg = flat[MEMREG_OFF +: MEMREG_W];
    b.memwr  = flat[MEMWR_OFF  +: MEMWR_W];
    b.alucon = flat[ALUCON_OFF +: ALUCON_W];
    b.alusrc = flat[ALUSRC_OFF +: ALUSRC_W];
    b.regdst = flat[REGDST_OFF +: REGDST_W];
    return b;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and
// synchronous FLUSH. Define PIPE_STAGE_PERF_EN to add stall/bubble/flush counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH       = CTRL_W,
  parameter bit          ZERO_BUBBLE = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             FLUSH,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  stage_state_e     state, state_nxt;
  logic [WIDTH-1:0] main_data, main_nxt;
  logic [WIDTH-1:0] skid_data, skid_nxt;
  logic             accept;
  logic             fire;

  // Ready is a pure decode of the state flop: no path from out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready & ~FLUSH;
  assign fire      = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_data;
    skid_nxt  = skid_data;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          main_nxt  = in_data;
        end
      end
      ONE: begin
        if (accept && fire) begin
          main_nxt = in_data;
        end else if (accept) begin
          state_nxt = TWO;
          skid_nxt  = in_data;
        end else if (fire) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (fire) begin
          state_nxt = ONE;
          main_nxt  = skid_data;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (FLUSH) begin
      state_nxt = EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_nxt;
      main_data <= main_nxt;
      skid_data <= skid_nxt;
    end
  end

  generate
    if (ZERO_BUBBLE) begin : g_zero_bubble
      assign out_data = out_valid ? main_data : '0;
    end else begin : g_hold_bubble
      assign out_data = main_data;
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_EN
  // A valid skid entry implies a valid main entry, so out_valid covers "any entry".
  pipe_sat_counter #(.W(32)) u_stall_cnt (
    .clk   (CLK),
    .clr   (CLR),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.W(32)) u_bubble_cnt (
    .clk   (CLK),
    .clr   (CLR),
    .inc   (~out_valid),
    .count (bubble_cnt)
  );

  pipe_sat_counter #(.W(16)) u_flush_cnt (
    .clk   (CLK),
    .clr   (CLR),
    .inc   (FLUSH & out_valid),
    .count (flush_cnt)
  );
`endif

endmodule
